// File: rtl/order_issue_unit_pkg.sv
// ============================================================================
// Module : order_pkg
// Brief  : Shared widths, limits and FSM state type for the order issue unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package order_pkg;

    localparam int FIFO_DATA  = 25;
    localparam int ORDER_IMGS = 50;
    localparam int MAX_ORDERS = 5;
    localparam int WCNT_W     = 6;
    localparam int PEND_W     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/order_out_fifo.sv
// ============================================================================
// Module : order_out_fifo
// Brief  : Synchronous first-word-fall-through FIFO with full/empty/free count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module order_out_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == c_DEPTH_CNT);
    assign empty   = (r_count == '0);
    assign free    = c_DEPTH_CNT - r_count;
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is cleared so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/order_issue_unit.sv
// ============================================================================
// Module : order_issue_unit
// Brief  : Issues orders to the receive unit, collects ORDER_IMGS words per
//          order and streams them out. Optional watchdog: ORDER_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module order_issue_unit
    import order_pkg::*;
#(
    parameter int OFIFO_DEPTH = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  order_come,
    input  logic                  order_full,
    input  logic                  no_order,
    output logic                  rec_en,
    input  logic                  sending,
    input  logic [FIFO_DATA-1:0]  axi_in,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [FIFO_DATA-1:0]  dout_data,
    output logic                  order_done,
    output logic [PEND_W-1:0]     pending,
    output logic                  err_overflow,
    output logic                  err_timeout,
    input  logic                  err_clr
);

    localparam int c_FREE_W = $clog2(OFIFO_DEPTH) + 1;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [PEND_W-1:0]   r_pending;
    logic                r_order_come;
    logic                r_order_done;
    logic                r_rec_en_q;
    logic                r_err_ovf;

    logic                w_accept;
    logic                w_wstb;
    logic                w_last_word;
    logic                w_done;
    logic                w_idle_hit;
    logic [PEND_W-1:0]   w_pending_nxt;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_FREE_W-1:0] w_free;

    // rst_n keeps the handshake closed while the block is held in reset.
    assign req_ready     = rst_n && !order_full && (r_pending < PEND_W'(MAX_ORDERS)) && !r_order_come;
    assign w_accept      = req_valid && req_ready;
    assign rec_en        = (r_state == COLLECT) && (w_free >= c_FREE_W'(2));
    assign w_wstb        = r_rec_en_q & sending;
    assign w_last_word   = w_wstb && (r_word_cnt == WCNT_W'(ORDER_IMGS - 1));
    assign w_done        = (r_state == DONE);
    assign w_pending_nxt = r_pending + PEND_W'(w_accept) - PEND_W'(w_done);

    assign order_come    = r_order_come;
    assign order_done    = r_order_done;
    assign pending       = r_pending;
    assign err_overflow  = r_err_ovf;
    assign dout_valid    = ~w_fifo_empty;

    order_out_fifo #(
        .WIDTH (FIFO_DATA),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wstb),
        .wr_data (axi_in),
        .rd_en   (dout_ready),
        .rd_data (dout_data),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .free    (w_free)
    );

`ifdef ORDER_TIMEOUT_EN
    localparam logic [9:0] c_TO_LAST = 10'(TIMEOUT_CYC - 1);

    logic [9:0] r_idle_cnt;
    logic       r_no_order_q;
    logic       r_err_to;
    logic       w_no_order_hit;

    assign w_idle_hit     = (r_state == COLLECT) && !w_wstb && (r_idle_cnt == c_TO_LAST);
    assign w_no_order_hit = r_no_order_q && no_order && (r_pending != '0);
    assign err_timeout    = r_err_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt   <= '0;
            r_no_order_q <= 1'b0;
            r_err_to     <= 1'b0;
        end else begin
            if ((r_state != COLLECT) || w_wstb) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            r_no_order_q <= no_order && (r_pending != '0);
            if (w_idle_hit || w_no_order_hit) begin
                r_err_to <= 1'b1;
            end else if (err_clr) begin
                r_err_to <= 1'b0;
            end
        end
    end
`else
    logic w_unused;

    assign w_idle_hit  = 1'b0;
    assign err_timeout = 1'b0;
    assign w_unused    = no_order | (TIMEOUT_CYC == 0);
`endif

    // A word landing during DONE belongs to the next order and seeds its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_pending    <= '0;
            r_order_come <= 1'b0;
            r_order_done <= 1'b0;
            r_rec_en_q   <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_order_come <= w_accept;
            r_order_done <= (r_state == COLLECT) && w_last_word;
            r_rec_en_q   <= rec_en;
            r_pending    <= w_pending_nxt;

            if (w_wstb && w_fifo_full) begin
                r_err_ovf <= 1'b1;
            end else if (err_clr) begin
                r_err_ovf <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_last_word || w_idle_hit) begin
                        r_word_cnt <= '0;
                        r_state    <= DONE;
                    end else if (w_wstb) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_word_cnt <= WCNT_W'(w_wstb);
                    r_state    <= (w_pending_nxt != '0) ? COLLECT : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
